regfile_mp: RTL and testbench

- Parametrised multi-port register file for the datapath. Replaces the fixed 8x16, two-write-port register file.
- Adds a configurable number of write and read ports, synchronous reset, defined write-conflict priority and a per-register busy scoreboard for the issue logic.
- Sits between the decode/issue stage (reads, scoreboard) and the writeback stage (writes). Exposes a flat register image for the autograder/debug.

---
 rtl/regfile_mp.sv | 76 +++++++
 tb/tb_regfile_mp.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with write-conflict priority and busy scoreboard.
// Optional same-cycle write-to-read forwarding is enabled by defining REGFILE_MP_WR_BYPASS_EN.
module regfile_mp #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3,
    parameter int NUM_WR = 2,
    parameter int NUM_RD = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_WR-1:0]           wr_en,
    input  logic [NUM_WR*ADDR_W-1:0]    wr_addr,
    input  logic [NUM_WR*DATA_W-1:0]    wr_data,
    input  logic [NUM_RD*ADDR_W-1:0]    rd_addr,
    output logic [NUM_RD*DATA_W-1:0]    rd_data,
    input  logic                        busy_set,
    input  logic [ADDR_W-1:0]           busy_addr,
    output logic [(2**ADDR_W)-1:0]      busy,
    output logic [(2**ADDR_W)*DATA_W-1:0] regs_flat
);

    localparam int NREGS = 2**ADDR_W;

    logic [DATA_W-1:0] mem [NREGS];

    // Ascending port order lets the highest-numbered port's assignment land last and win.
    // A busy_set after the write-clears keeps a freshly issued producer marked pending.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NREGS; r++) begin
                mem[r] <= '0;
            end
            busy <= '0;
        end else begin
            for (int i = 0; i < NUM_WR; i++) begin
                if (wr_en[i]) begin
                    mem[wr_addr[i*ADDR_W +: ADDR_W]]  <= wr_data[i*DATA_W +: DATA_W];
                    busy[wr_addr[i*ADDR_W +: ADDR_W]] <= 1'b0;
                end
            end
            if (busy_set) begin
                busy[busy_addr] <= 1'b1;
            end
        end
    end

    for (genvar r = 0; r < NREGS; r++) begin : g_flat
        assign regs_flat[r*DATA_W +: DATA_W] = mem[r];
    end

    for (genvar j = 0; j < NUM_RD; j++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] val;

        assign ra = rd_addr[j*ADDR_W +: ADDR_W];

`ifdef REGFILE_MP_WR_BYPASS_EN
        // Forward from the highest-numbered matching write port, matching commit priority.
        always_comb begin
            val = mem[ra];
            if (!rst) begin
                for (int i = 0; i < NUM_WR; i++) begin
                    if (wr_en[i] && (wr_addr[i*ADDR_W +: ADDR_W] == ra)) begin
                        val = wr_data[i*DATA_W +: DATA_W];
                    end
                end
            end
        end
`else
        assign val = mem[ra];
`endif

        assign rd_data[j*DATA_W +: DATA_W] = val;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed steps plus randomized traffic against a behavioural model.
// Honours REGFILE_MP_WR_BYPASS_EN when predicting same-cycle reads.
module tb_regfile_mp;

    logic         clk = 1'b0;
    logic         rst;
    logic [1:0]   wr_en;
    logic [5:0]   wr_addr;
    logic [31:0]  wr_data;
    logic [5:0]   rd_addr;
    logic [31:0]  rd_data;
    logic         busy_set;
    logic [2:0]   busy_addr;
    logic [7:0]   busy;
    logic [127:0] regs_flat;

    logic [15:0]  m_regs [8];
    logic [7:0]   m_busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    regfile_mp #(.DATA_W(16), .ADDR_W(3), .NUM_WR(2), .NUM_RD(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .busy_set  (busy_set),
        .busy_addr (busy_addr),
        .busy      (busy),
        .regs_flat (regs_flat)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference read: what the register file should return for an index right now.
    function automatic logic [15:0] expRead(input logic [2:0] a);
`ifdef REGFILE_MP_WR_BYPASS_EN
        if (!rst) begin
            if (wr_en[1] && wr_addr[5:3] == a) return wr_data[31:16];
            if (wr_en[0] && wr_addr[2:0] == a) return wr_data[15:0];
        end
`endif
        return m_regs[a];
    endfunction

    function automatic logic [127:0] flatModel();
        logic [127:0] f;
        for (int r = 0; r < 8; r++) f[r*16 +: 16] = m_regs[r];
        return f;
    endfunction

    // Model of one clock edge, written straight from the behavioural rules.
    task automatic modelEdge();
        if (rst) begin
            for (int r = 0; r < 8; r++) m_regs[r] = 16'h0;
            m_busy = 8'h0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (wr_en[i]) begin
                    m_regs[wr_addr[i*3 +: 3]] = wr_data[i*16 +: 16];
                    m_busy[wr_addr[i*3 +: 3]] = 1'b0;
                end
            end
            if (busy_set) m_busy[busy_addr] = 1'b1;
        end
    endtask

    task automatic applyStimulus(input logic r, input logic [1:0] en,
                                 input logic [2:0] a0, input logic [15:0] d0,
                                 input logic [2:0] a1, input logic [15:0] d1,
                                 input logic [2:0] ra0, input logic [2:0] ra1,
                                 input logic bs, input logic [2:0] ba);
        rst       = r;
        wr_en     = en;
        wr_addr   = {a1, a0};
        wr_data   = {d1, d0};
        rd_addr   = {ra1, ra0};
        busy_set  = bs;
        busy_addr = ba;
    endtask

    // Checks same-cycle reads, takes one clock edge, then checks the committed state.
    task automatic checkOutput(input string tag);
        #1;
        check({tag, "_rd0_pre"}, 128'(rd_data[15:0]),  128'(expRead(rd_addr[2:0])));
        check({tag, "_rd1_pre"}, 128'(rd_data[31:16]), 128'(expRead(rd_addr[5:3])));
        @(posedge clk);
        modelEdge();
        #1;
        check({tag, "_regs"}, regs_flat, flatModel());
        check({tag, "_busy"}, 128'(busy), 128'(m_busy));
        check({tag, "_rd0_post"}, 128'(rd_data[15:0]), 128'(expRead(rd_addr[2:0])));
    endtask

    initial begin
        for (int r = 0; r < 8; r++) m_regs[r] = 16'hxxxx;
        m_busy = 8'hxx;
        applyStimulus(1'b1, 2'b00, 3'd0, 16'h0, 3'd0, 16'h0, 3'd0, 3'd0, 1'b0, 3'd0);
        @(posedge clk);
        modelEdge();
        #1;
        check("reset_regs", regs_flat, 128'h0);
        check("reset_busy", 128'(busy), 128'h0);

        // Random writes, then reset clears everything.
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b0, 2'b11, 3'($urandom_range(0, 7)), 16'($urandom),
                          3'($urandom_range(0, 7)), 16'($urandom), 3'd0, 3'd1, 1'b1, 3'($urandom_range(0, 7)));
            checkOutput("prefill");
        end
        applyStimulus(1'b1, 2'b00, 3'd0, 16'h0, 3'd0, 16'h0, 3'd2, 3'd3, 1'b0, 3'd0);
        checkOutput("rst_mid");
        check("rst_mid_regs0", regs_flat, 128'h0);
        check("rst_mid_busy0", 128'(busy), 128'h0);
        for (int a = 0; a < 8; a += 2) begin
            applyStimulus(1'b0, 2'b00, 3'd0, 16'h0, 3'd0, 16'h0, 3'(a), 3'(a + 1), 1'b0, 3'd0);
            #1;
            check("rd_after_rst", 128'(rd_data), 128'h0);
            checkOutput("rd_after_rst");
        end

        // Dual distinct writes.
        applyStimulus(1'b0, 2'b11, 3'd2, 16'h1234, 3'd5, 16'hABCD, 3'd0, 3'd0, 1'b0, 3'd0);
        checkOutput("dual_wr");
        applyStimulus(1'b0, 2'b00, 3'd0, 16'h0, 3'd0, 16'h0, 3'd2, 3'd5, 1'b0, 3'd0);
        #1;
        check("dual_r2", 128'(rd_data[15:0]), 128'h1234);
        check("dual_r5", 128'(rd_data[31:16]), 128'hABCD);
        checkOutput("dual_rd");

        // Write conflict: highest port wins, then port0 alone.
        applyStimulus(1'b0, 2'b11, 3'd3, 16'h0001, 3'd3, 16'h0002, 3'd3, 3'd3, 1'b0, 3'd0);
        checkOutput("conflict");
        check("conflict_r3", 128'(regs_flat[63:48]), 128'h0002);
        applyStimulus(1'b0, 2'b01, 3'd3, 16'h0001, 3'd3, 16'h0002, 3'd3, 3'd3, 1'b0, 3'd0);
        checkOutput("port0_only");
        check("port0_r3", 128'(regs_flat[63:48]), 128'h0001);

        // Same-cycle read of a written index.
        applyStimulus(1'b0, 2'b01, 3'd4, 16'h0011, 3'd0, 16'h0, 3'd0, 3'd0, 1'b0, 3'd0);
        checkOutput("r4_init");
        applyStimulus(1'b0, 2'b01, 3'd4, 16'h00FF, 3'd0, 16'h0, 3'd4, 3'd4, 1'b0, 3'd0);
        #1;
`ifdef REGFILE_MP_WR_BYPASS_EN
        check("same_cycle_rd", 128'(rd_data[15:0]), 128'h00FF);
`else
        check("same_cycle_rd", 128'(rd_data[15:0]), 128'h0011);
`endif
        checkOutput("same_cycle");
        applyStimulus(1'b0, 2'b00, 3'd0, 16'h0, 3'd0, 16'h0, 3'd4, 3'd4, 1'b0, 3'd0);
        #1;
        check("next_cycle_rd", 128'(rd_data[15:0]), 128'h00FF);
        checkOutput("next_cycle");

        // Scoreboard behaviour.
        applyStimulus(1'b0, 2'b00, 3'd0, 16'h0, 3'd0, 16'h0, 3'd0, 3'd0, 1'b1, 3'd6);
        checkOutput("busy_set6");
        check("busy6_set", 128'(busy[6]), 128'h1);
        applyStimulus(1'b0, 2'b10, 3'd0, 16'h0, 3'd6, 16'h7777, 3'd6, 3'd6, 1'b0, 3'd0);
        checkOutput("busy_clr6");
        check("busy6_clr", 128'(busy[6]), 128'h0);
        applyStimulus(1'b0, 2'b01, 3'd1, 16'h5A5A, 3'd0, 16'h0, 3'd1, 3'd1, 1'b1, 3'd1);
        checkOutput("busy_set_wins");
        check("busy1_set", 128'(busy[1]), 128'h1);
        check("r1_upd", 128'(regs_flat[31:16]), 128'h5A5A);

        // Reset dominates writes and busy_set.
        applyStimulus(1'b1, 2'b11, 3'd2, 16'hFFFF, 3'd7, 16'hEEEE, 3'd2, 3'd7, 1'b1, 3'd7);
        checkOutput("rst_dom");
        check("rst_dom_regs", regs_flat, 128'h0);
        check("rst_dom_busy", 128'(busy), 128'h0);

        // Randomized traffic with occasional reset.
        for (int k = 0; k < 400; k++) begin
            applyStimulus(1'($urandom_range(0, 31) == 0), 2'($urandom_range(0, 3)),
                          3'($urandom_range(0, 7)), 16'($urandom),
                          3'($urandom_range(0, 7)), 16'($urandom),
                          3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                          1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
            checkOutput("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
